// File: rtl/rv_muldiv_if.sv
// rv_muldiv_if: request/response bundle between the core and the M-extension unit.
// The core side is the master; the execution unit is the slave.
interface rv_muldiv_if #(
  parameter int XLEN = 32
) ();
  logic            kill;
  logic            req_valid;
  logic            req_ready;
  logic [2:0]      req_funct3;
  logic [XLEN-1:0] req_a;
  logic [XLEN-1:0] req_b;
  logic            resp_valid;
  logic [XLEN-1:0] resp_result;
  logic            busy;

  modport master (
    output kill, req_valid, req_funct3, req_a, req_b,
    input  req_ready, resp_valid, resp_result, busy
  );

  modport slave (
    input  kill, req_valid, req_funct3, req_a, req_b,
    output req_ready, resp_valid, resp_result, busy
  );
endinterface

// File: rtl/rv_muldiv.sv
// rv_muldiv: iterative RISC-V MUL/MULH/MULHSU/MULHU/DIV/DIVU/REM/REMU unit.
// Shift-add multiply and restoring divide, one bit per cycle; optional single-cycle multiply.
module rv_muldiv #(
  parameter int XLEN     = 32,
  parameter bit FAST_MUL = 1'b0
) (
  input logic        clk,
  input logic        rst,
  rv_muldiv_if.slave bus
);
  localparam int              CW       = $clog2(XLEN);
  localparam logic [CW-1:0]   CNT_LOAD = CW'(XLEN - 1);
  localparam logic [CW-1:0]   CNT_ZERO = {CW{1'b0}};
  localparam logic [CW-1:0]   CNT_ONE  = CW'(1);
  localparam logic [XLEN-1:0] ZERO     = {XLEN{1'b0}};
  localparam logic [XLEN-1:0] ONES     = {XLEN{1'b1}};
  localparam logic [XLEN-1:0] MIN_NEG  = {1'b1, {(XLEN-1){1'b0}}};

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CALC  = 2'd1,
    FIXUP = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t              state_q, state_d;
  logic [2:0]          op_q, op_d;
  logic [XLEN-1:0]     opnd_q, opnd_d;
  logic [2*XLEN-1:0]   acc_q, acc_d;
  logic [CW-1:0]       cnt_q, cnt_d;
  logic                neg_q, neg_d;
  logic [XLEN-1:0]     res_q, res_d;

  logic [2:0]          f;
  logic                is_div, a_signed, b_signed, sa, sb, neg_in;
  logic                div_zero, div_ovf, special;
  logic [XLEN-1:0]     a_mag, b_mag, special_res;
  logic [2*XLEN-1:0]   fast_prod;
  logic [XLEN:0]       mul_sum, div_shift, div_diff;
  logic [2*XLEN-1:0]   mul_next, div_next, prod_fix;
  logic [XLEN-1:0]     quo_fix, rem_fix, fix_res;

  // Accept-time decode: signedness, magnitudes, negate flag and the early-exit cases.
  assign f           = bus.req_funct3;
  assign is_div      = f[2];
  assign a_signed    = (f == 3'b001) || (f == 3'b010) || (f[2] && !f[0]);
  assign b_signed    = (f == 3'b001) || (f[2] && !f[0]);
  assign sa          = a_signed && bus.req_a[XLEN-1];
  assign sb          = b_signed && bus.req_b[XLEN-1];
  assign a_mag       = sa ? (ZERO - bus.req_a) : bus.req_a;
  assign b_mag       = sb ? (ZERO - bus.req_b) : bus.req_b;
  assign neg_in      = (is_div && f[1]) ? sa : (sa ^ sb);
  assign div_zero    = is_div && (bus.req_b == ZERO);
  assign div_ovf     = is_div && !f[0] && (bus.req_a == MIN_NEG) && (bus.req_b == ONES);
  assign special     = div_zero || div_ovf;
  assign special_res = div_zero ? (f[1] ? bus.req_a : ONES) : (f[1] ? ZERO : bus.req_a);

  generate
    if (FAST_MUL) begin : g_fast_mul
      assign fast_prod = {ZERO, a_mag} * {ZERO, b_mag};
    end else begin : g_iter_mul
      assign fast_prod = {ZERO, ZERO};
    end
  endgenerate

  // acc holds {partial product, multiplier} for multiply and {remainder, quotient} for divide.
  assign mul_sum   = {1'b0, acc_q[2*XLEN-1:XLEN]} + (acc_q[0] ? {1'b0, opnd_q} : {1'b0, ZERO});
  assign mul_next  = {mul_sum, acc_q[XLEN-1:1]};
  assign div_shift = {acc_q[2*XLEN-1:XLEN], acc_q[XLEN-1]};
  assign div_diff  = div_shift - {1'b0, opnd_q};
  assign div_next  = div_diff[XLEN] ? {div_shift[XLEN-1:0], acc_q[XLEN-2:0], 1'b0}
                                    : {div_diff[XLEN-1:0],  acc_q[XLEN-2:0], 1'b1};

  assign prod_fix = neg_q ? ({ZERO, ZERO} - acc_q) : acc_q;
  assign quo_fix  = neg_q ? (ZERO - acc_q[XLEN-1:0]) : acc_q[XLEN-1:0];
  assign rem_fix  = neg_q ? (ZERO - acc_q[2*XLEN-1:XLEN]) : acc_q[2*XLEN-1:XLEN];
  assign fix_res  = op_q[2] ? (op_q[1] ? rem_fix : quo_fix)
                            : ((op_q[1:0] == 2'b00) ? prod_fix[XLEN-1:0] : prod_fix[2*XLEN-1:XLEN]);

  // Next-state and datapath update.
  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    opnd_d  = opnd_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    neg_d   = neg_q;
    res_d   = res_q;
    case (state_q)
      IDLE: begin
        if (bus.req_valid && !bus.kill) begin
          op_d  = f;
          neg_d = neg_in;
          if (special) begin
            res_d   = special_res;
            state_d = DONE;
          end else if (FAST_MUL && !is_div) begin
            acc_d   = fast_prod;
            state_d = FIXUP;
          end else begin
            opnd_d  = is_div ? b_mag : a_mag;
            acc_d   = {ZERO, (is_div ? a_mag : b_mag)};
            cnt_d   = CNT_LOAD;
            state_d = CALC;
          end
        end else begin
          state_d = IDLE;
        end
      end
      CALC: begin
        if (bus.kill) begin
          state_d = IDLE;
        end else begin
          acc_d = op_q[2] ? div_next : mul_next;
          if (cnt_q == CNT_ZERO) begin
            state_d = FIXUP;
          end else begin
            cnt_d = cnt_q - CNT_ONE;
          end
        end
      end
      FIXUP: begin
        if (bus.kill) begin
          state_d = IDLE;
        end else begin
          res_d   = fix_res;
          state_d = DONE;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and datapath registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      op_q    <= 3'b000;
      opnd_q  <= ZERO;
      acc_q   <= {ZERO, ZERO};
      cnt_q   <= CNT_ZERO;
      neg_q   <= 1'b0;
      res_q   <= ZERO;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      opnd_q  <= opnd_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      neg_q   <= neg_d;
      res_q   <= res_d;
    end
  end

  assign bus.req_ready   = (state_q == IDLE);
  assign bus.busy        = (state_q != IDLE);
  assign bus.resp_valid  = (state_q == DONE);
  assign bus.resp_result = res_q;
endmodule

// File: tb/tb_rv_muldiv.sv
// tb_rv_muldiv: directed vectors for the 32-bit unit plus a reduced XLEN=8 sweep
// (iterative and fast multiply) against an arithmetic reference model.
module tb_rv_muldiv;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  rv_muldiv_if #(.XLEN(32)) b32 ();
  rv_muldiv_if #(.XLEN(8))  s8 ();
  rv_muldiv_if #(.XLEN(8))  f8 ();

  rv_muldiv #(.XLEN(32), .FAST_MUL(1'b0)) u_b32 (.clk(clk), .rst(rst), .bus(b32.slave));
  rv_muldiv #(.XLEN(8),  .FAST_MUL(1'b0)) u_s8  (.clk(clk), .rst(rst), .bus(s8.slave));
  rv_muldiv #(.XLEN(8),  .FAST_MUL(1'b1)) u_f8  (.clk(clk), .rst(rst), .bus(f8.slave));

  int          sel = 0;
  logic        dv_valid = 1'b0;
  logic        dv_kill = 1'b0;
  logic [2:0]  dv_f = 3'd0;
  logic [31:0] dv_a = 32'd0;
  logic [31:0] dv_b = 32'd0;

  assign b32.req_valid  = dv_valid && (sel == 0);
  assign s8.req_valid   = dv_valid && (sel == 1);
  assign f8.req_valid   = dv_valid && (sel == 2);
  assign b32.kill       = dv_kill && (sel == 0);
  assign s8.kill        = dv_kill && (sel == 1);
  assign f8.kill        = dv_kill && (sel == 2);
  assign b32.req_funct3 = dv_f;
  assign s8.req_funct3  = dv_f;
  assign f8.req_funct3  = dv_f;
  assign b32.req_a      = dv_a;
  assign b32.req_b      = dv_b;
  assign s8.req_a       = dv_a[7:0];
  assign s8.req_b       = dv_b[7:0];
  assign f8.req_a       = dv_a[7:0];
  assign f8.req_b       = dv_b[7:0];

  int          nvec = 0;
  int          nerr = 0;
  logic        armed = 1'b0;
  logic        done = 1'b0;
  int          cyc = 0;
  int          exp_lat = 0;
  logic [31:0] exp_res = 32'd0;

  logic        rv_sel, rr_sel, busy_sel;
  logic [31:0] res_sel;
  always_comb begin
    rv_sel = b32.resp_valid;  rr_sel = b32.req_ready;  busy_sel = b32.busy;  res_sel = b32.resp_result;
    case (sel)
      1: begin rv_sel = s8.resp_valid; rr_sel = s8.req_ready; busy_sel = s8.busy; res_sel = {24'd0, s8.resp_result}; end
      2: begin rv_sel = f8.resp_valid; rr_sel = f8.req_ready; busy_sel = f8.busy; res_sel = {24'd0, f8.resp_result}; end
      default: ;
    endcase
  end

  // Reference model: plain integer arithmetic at width xl (xl <= 32).
  function automatic logic [31:0] ref_op(input logic [2:0] f, input logic [31:0] a_in,
                                         input logic [31:0] b_in, input int xl);
    logic [63:0] mask, ua, ub, r;
    longint      sa, sb, sp, minv;
    mask = (64'd1 << xl) - 64'd1;
    ua   = {32'd0, a_in} & mask;
    ub   = {32'd0, b_in} & mask;
    sa   = ua[xl-1] ? longint'(ua) - longint'(64'd1 << xl) : longint'(ua);
    sb   = ub[xl-1] ? longint'(ub) - longint'(64'd1 << xl) : longint'(ub);
    minv = -(longint'(1) << (xl - 1));
    case (f)
      3'd0: r = ua * ub;
      3'd1: begin sp = sa * sb; r = sp >>> xl; end
      3'd2: begin sp = sa * longint'(ub); r = sp >>> xl; end
      3'd3: r = (ua * ub) >> xl;
      3'd4: begin
        if (ub == 64'd0) r = mask;
        else if (sa == minv && sb == -1) r = ua;
        else begin sp = sa / sb; r = sp; end
      end
      3'd5: r = (ub == 64'd0) ? mask : ua / ub;
      3'd6: begin
        if (ub == 64'd0) r = ua;
        else if (sa == minv && sb == -1) r = 64'd0;
        else begin sp = sa % sb; r = sp; end
      end
      3'd7: r = (ub == 64'd0) ? ua : ua % ub;
      default: r = 64'd0;
    endcase
    r = r & mask;
    return r[31:0];
  endfunction

  function automatic int ref_lat(input logic [2:0] f, input logic [31:0] a_in,
                                 input logic [31:0] b_in, input int xl, input bit fast);
    logic [31:0] mask;
    mask = 32'((64'd1 << xl) - 64'd1);
    if (f[2] && (((b_in & mask) == 32'd0) ||
                 (!f[0] && (a_in & mask) == (32'd1 << (xl - 1)) && (b_in & mask) == mask)))
      return 1;
    if (!f[2] && fast) return 2;
    return xl + 2;
  endfunction

  task automatic chk_model(input string nm, input logic [2:0] f, input logic [31:0] a,
                           input logic [31:0] b, input int xl, input logic [31:0] want);
    logic [31:0] got;
    got = ref_op(f, a, b, xl);
    nvec++;
    if (got !== want) begin
      nerr++;
      $display("FAIL model_%s: got %h, expected %h", nm, got, want);
    end
  endtask

  // Single compare process: response timing/value, busy flags, and stray pulses on every DUT.
  always @(negedge clk) begin
    logic was;
    was = armed;
    if (armed) begin
      cyc = cyc + 1;
      if (rr_sel !== 1'b0 || busy_sel !== 1'b1) begin
        nerr++;
        $display("FAIL busy_flags: dut %0d cycle %0d ready=%b busy=%b, expected ready=0 busy=1",
                 sel, cyc, rr_sel, busy_sel);
      end
      if (rv_sel === 1'b1) begin
        nvec++;
        if (cyc != exp_lat || res_sel !== exp_res) begin
          nerr++;
          $display("FAIL resp: dut %0d got %h at cycle %0d, expected %h at cycle %0d",
                   sel, res_sel, cyc, exp_res, exp_lat);
        end
        armed = 1'b0;
        done  = 1'b1;
      end else if (cyc > exp_lat + 4) begin
        nvec++;
        nerr++;
        $display("FAIL timeout: dut %0d no resp_valid after %0d cycles, expected at cycle %0d",
                 sel, cyc, exp_lat);
        armed = 1'b0;
        done  = 1'b1;
      end
    end
    if ((b32.resp_valid && !(was && sel == 0)) || (s8.resp_valid && !(was && sel == 1)) ||
        (f8.resp_valid && !(was && sel == 2))) begin
      nerr++;
      $display("FAIL stray_resp: resp_valid b32=%b s8=%b f8=%b, expected none",
               b32.resp_valid, s8.resp_valid, f8.resp_valid);
    end
    if (b32.busy === b32.req_ready || s8.busy === s8.req_ready || f8.busy === f8.req_ready) begin
      nerr++;
      $display("FAIL busy_vs_ready: busy equals req_ready on some unit, expected complement");
    end
  end

  // Called just after a falling edge; returns just after the falling edge of the ready cycle.
  task automatic run_op(input int s, input logic [2:0] f, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] er, input int el);
    sel = s; dv_f = f; dv_a = a; dv_b = b; dv_valid = 1'b1;
    @(posedge clk);
    #1;
    dv_valid = 1'b0; dv_a = $urandom; dv_b = $urandom; dv_f = 3'($urandom_range(7, 0));
    exp_res = er; exp_lat = el; cyc = 0; done = 1'b0; armed = 1'b1;
    wait (done);
    @(negedge clk);
    nvec++;
    if (rr_sel !== 1'b1) begin
      nerr++;
      $display("FAIL ready_after: dut %0d req_ready=%b after response, expected 1", s, rr_sel);
    end
  endtask

  task automatic chk_idle(input string nm, input logic [31:0] want_res);
    nvec++;
    if (rr_sel !== 1'b1 || busy_sel !== 1'b0 || rv_sel !== 1'b0 || res_sel !== want_res) begin
      nerr++;
      $display("FAIL %s: ready=%b busy=%b valid=%b result=%h, expected 1 0 0 %h",
               nm, rr_sel, busy_sel, rv_sel, res_sel, want_res);
    end
  endtask

  logic [7:0]  vals [12] = '{8'h00, 8'h01, 8'h02, 8'h03, 8'h07, 8'h55,
                             8'h7F, 8'h80, 8'h81, 8'hAA, 8'hFE, 8'hFF};
  logic [31:0] prev_res;

  initial begin
    chk_model("mul",    3'd0, 32'd7,        32'hFFFFFFFD, 32, 32'hFFFFFFEB);
    chk_model("mulh",   3'd1, 32'h80000000, 32'h80000000, 32, 32'h40000000);
    chk_model("mulhsu", 3'd2, 32'hFFFFFFFF, 32'hFFFFFFFF, 32, 32'hFFFFFFFF);
    chk_model("mulhu",  3'd3, 32'hFFFFFFFF, 32'hFFFFFFFF, 32, 32'hFFFFFFFE);
    chk_model("div",    3'd4, 32'hFFFFFFF9, 32'd2,        32, 32'hFFFFFFFD);
    chk_model("rem",    3'd6, 32'hFFFFFFF9, 32'd2,        32, 32'hFFFFFFFF);
    chk_model("div_ovf",3'd4, 32'h80000000, 32'hFFFFFFFF, 32, 32'h80000000);
    chk_model("rem_z",  3'd6, 32'd5,        32'd0,        32, 32'd5);
    chk_model("div8",   3'd4, 32'h80,       32'hFF,       8,  32'h80);
    chk_model("mulhu8", 3'd3, 32'hFF,       32'hFF,       8,  32'hFE);

    repeat (3) @(negedge clk);
    for (int s = 0; s < 3; s++) begin
      sel = s;
      #1;
      chk_idle("reset_state", 32'd0);
    end
    @(negedge clk);
    rst = 1'b0;

    run_op(0, 3'd0, 32'd7,        32'hFFFFFFFD, 32'hFFFFFFEB, 34);
    run_op(0, 3'd1, 32'h80000000, 32'h80000000, 32'h40000000, 34);
    run_op(0, 3'd2, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 34);
    run_op(0, 3'd3, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 34);
    run_op(0, 3'd4, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFD, 34);
    run_op(0, 3'd6, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 34);
    run_op(0, 3'd5, 32'd100,      32'd7,        32'd14,       34);
    run_op(0, 3'd7, 32'd100,      32'd7,        32'd2,        34);
    run_op(0, 3'd5, 32'd5,        32'd0,        32'hFFFFFFFF, 1);
    run_op(0, 3'd6, 32'd5,        32'd0,        32'd5,        1);
    run_op(0, 3'd4, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 1);
    run_op(0, 3'd6, 32'h80000000, 32'hFFFFFFFF, 32'd0,        1);

    // Abort a divide in cycle 10; the unit must be idle in cycle 11 with the old result.
    prev_res = res_sel;
    dv_f = 3'd4; dv_a = 32'd1000; dv_b = 32'd3; dv_valid = 1'b1;
    @(posedge clk);
    #1;
    dv_valid = 1'b0;
    repeat (10) @(negedge clk);
    dv_kill = 1'b1;
    @(negedge clk);
    dv_kill = 1'b0;
    chk_idle("kill_calc", prev_res);
    repeat (40) @(negedge clk);
    run_op(0, 3'd0, 32'd3, 32'd4, 32'd12, 34);

    // kill with req_valid in IDLE: a special-case request would otherwise answer in cycle 1.
    prev_res = res_sel;
    dv_f = 3'd5; dv_a = 32'd5; dv_b = 32'd0; dv_valid = 1'b1; dv_kill = 1'b1;
    @(posedge clk);
    #1;
    dv_valid = 1'b0; dv_kill = 1'b0;
    @(negedge clk);
    chk_idle("kill_idle", prev_res);
    repeat (3) @(negedge clk);

    // Reset in the middle of CALC.
    dv_f = 3'd5; dv_a = 32'd100; dv_b = 32'd7; dv_valid = 1'b1;
    @(posedge clk);
    #1;
    dv_valid = 1'b0;
    repeat (5) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk_idle("reset_mid", 32'd0);
    run_op(0, 3'd7, 32'd100, 32'd7, 32'd2, 34);

    for (int s = 1; s < 3; s++) begin
      for (int f = 0; f < 8; f++) begin
        for (int i = 0; i < 12; i++) begin
          for (int j = 0; j < 12; j++) begin
            run_op(s, 3'(f), {24'd0, vals[i]}, {24'd0, vals[j]},
                   ref_op(3'(f), {24'd0, vals[i]}, {24'd0, vals[j]}, 8),
                   ref_lat(3'(f), {24'd0, vals[i]}, {24'd0, vals[j]}, 8, s == 2));
          end
        end
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
